wave_control: RTL and testbench
===============================

WAVE_CONTROL -- requirements
Module: wave_control

Interface
REQ-001 SHALL: parameter FRAMES_PER_STEP, default 300, frame ticks between plane-count increments (range 1..65535).
REQ-002 SHALL: parameter START_AMOUNT, default 1, plane count loaded on start (range 1..MAX_AMOUNT).
REQ-003 SHALL: parameter MAX_AMOUNT, default 10, plane-count ceiling (range 1..10).
REQ-004 SHALL: clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL: frame_tick  input  1  one-clk pulse per video frame.
REQ-007 SHALL: start  input  1  one-clk pulse; begins or restarts a game.
REQ-008 SHALL: pause  input  1  level; while high, frame ticks are ignored.
REQ-009 SHALL: game_over  input  1  one-clk pulse; freezes progression.
REQ-010 SHALL: player_hit  input  1  one-clk pulse; used only when HIT_PENALTY_EN is defined.
REQ-011 SHALL: plane_amount  output  4  active enemy count, 0..MAX_AMOUNT; feeds the enemy enable/visibility mask stage.
REQ-012 SHALL: step_pulse  output  1  one-clk pulse on each count change made by ramp or penalty.
REQ-013 SHALL: state  output  2  FSM state: IDLE=0, RUN=1, MAXED=2, OVER=3.

Function
REQ-014 SHALL: FSM states and outputs:
- IDLE: plane_amount=0.
- RUN: plane_amount ramps.
- MAXED: plane_amount=MAX_AMOUNT, held.
- OVER: plane_amount frozen at its last value.
REQ-015 SHALL: start in any state, on the next edge:
- plane_amount=START_AMOUNT and frame_cnt=0;
- state=MAXED if START_AMOUNT==MAX_AMOUNT, else RUN.
REQ-016 SHALL: in RUN, frame_cnt (16-bit, internal) advances only when frame_tick=1 and pause=0.
REQ-017 SHALL: in RUN, a counted tick with frame_cnt==FRAMES_PER_STEP-1 causes:
- frame_cnt=0 and plane_amount+1;
- step_pulse=1 for exactly one clk;
- state=MAXED if the new value equals MAX_AMOUNT.
REQ-018 SHALL: latency from the qualifying frame_tick edge to the updated plane_amount is one clk, registered output.
REQ-019 SHALL: in MAXED, frame_cnt stays 0 and frame ticks have no effect.
REQ-020 SHALL: game_over in RUN or MAXED moves to OVER; plane_amount and frame_cnt freeze, and step_pulse stays 0.
REQ-021 SHALL: game_over in IDLE or OVER is ignored.
REQ-022 SHALL: same-cycle priority is start > game_over > player_hit > ramp step; losing events are discarded, not queued.
REQ-023 SHALL: plane_amount never exceeds MAX_AMOUNT and never wraps.
REQ-024 SHALL: pause has no effect on start, game_over or player_hit.

Reset
REQ-025 SHALL: asserting reset immediately forces state=IDLE, plane_amount=0, frame_cnt=0 and step_pulse=0, including mid-ramp.
REQ-026 SHALL: after release, the block stays in IDLE until start; frame ticks in IDLE are ignored.

Configuration
REQ-027 SHALL: macro HIT_PENALTY_EN, when defined, makes player_hit in RUN or MAXED do all of:
- plane_amount-1, floored at START_AMOUNT;
- frame_cnt=0 and state=RUN;
- step_pulse=1, only if plane_amount actually changed.
REQ-028 SHALL: when HIT_PENALTY_EN is undefined, player_hit is ignored and the penalty logic is absent.

Verification
REQ-029 SHALL: FRAMES_PER_STEP=3, START=1, MAX=10; reset, start, 27 ticks -> amount reaches 10 on tick 27, state=MAXED, nine step_pulses total.
REQ-030 SHALL: same parameters; start, 2 ticks, pause=1, 5 ticks, pause=0, 1 tick -> amount=2 one clk after the last tick.
REQ-031 SHALL: amount=4 in RUN; game_over and frame_tick both on the final tick of a step -> state=OVER, amount=4, no step_pulse.
REQ-032 SHALL: amount=6; reset asserted asynchronously mid-cycle -> amount=0, state=IDLE before the next clk edge; start -> amount=1.
REQ-033 SHALL: HIT_PENALTY_EN defined, state MAXED; player_hit -> amount=9, state=RUN, one step_pulse; at amount=START, player_hit -> no change, no pulse.
REQ-034 SHALL: state OVER; start and game_over in the same clk -> RUN with amount=START_AMOUNT.

Source files
------------

// File: rtl/wave_control.sv
// rtl/wave_control.sv - enemy wave ramp controller; optional hit penalty under HIT_PENALTY_EN
module wave_control #(
    parameter int FRAMES_PER_STEP = 300,
    parameter int START_AMOUNT    = 1,
    parameter int MAX_AMOUNT      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       game_over,
    input  logic       player_hit,
    output logic [3:0] plane_amount,
    output logic       step_pulse,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        MAXED = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [3:0]  START_A  = 4'(START_AMOUNT);
    localparam logic [3:0]  MAX_A    = 4'(MAX_AMOUNT);
    localparam logic [15:0] LAST_CNT = 16'(FRAMES_PER_STEP - 1);

    state_t      state_q, state_d;
    logic [3:0]  amount_q, amount_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        step_q, step_d;
    logic        active;

    assign active = (state_q == RUN) || (state_q == MAXED);

`ifndef HIT_PENALTY_EN
    logic unused_player_hit;
    assign unused_player_hit = player_hit;
`endif

    // Next-state: start beats game_over beats player_hit beats the ramp step.
    always_comb begin
        state_d     = state_q;
        amount_d    = amount_q;
        frame_cnt_d = frame_cnt_q;
        step_d      = 1'b0;
        if (start) begin
            amount_d    = START_A;
            frame_cnt_d = 16'd0;
            state_d     = (START_A == MAX_A) ? MAXED : RUN;
        end else if (game_over && active) begin
            state_d = OVER;
`ifdef HIT_PENALTY_EN
        end else if (player_hit && active) begin
            frame_cnt_d = 16'd0;
            state_d     = RUN;
            if (amount_q > START_A) begin
                amount_d = amount_q - 4'd1;
                step_d   = 1'b1;
            end
`endif
        end else if ((state_q == RUN) && frame_tick && !pause) begin
            if (frame_cnt_q == LAST_CNT) begin
                frame_cnt_d = 16'd0;
                // A penalty can leave RUN sitting at the ceiling; never step past it.
                if (amount_q < MAX_A) begin
                    amount_d = amount_q + 4'd1;
                    step_d   = 1'b1;
                    if (amount_q + 4'd1 == MAX_A) begin
                        state_d = MAXED;
                    end
                end else begin
                    state_d = MAXED;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    // State registers, cleared asynchronously so reset acts mid-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            amount_q    <= 4'd0;
            frame_cnt_q <= 16'd0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            amount_q    <= amount_d;
            frame_cnt_q <= frame_cnt_d;
            step_q      <= step_d;
        end
    end

    assign plane_amount = amount_q;
    assign step_pulse   = step_q;
    assign state        = state_q;

endmodule

// File: tb/tb_wave_control.sv
// tb/tb_wave_control.sv - directed table and sequence checks for wave_control
module tb_wave_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, start, start2, pause, game_over, player_hit;
    logic [3:0] amt, amt2;
    logic       stp, stp2;
    logic [1:0] st, st2;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    wave_control #(.FRAMES_PER_STEP(3), .START_AMOUNT(1), .MAX_AMOUNT(10)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .pause(pause), .game_over(game_over), .player_hit(player_hit),
        .plane_amount(amt), .step_pulse(stp), .state(st)
    );

    wave_control #(.FRAMES_PER_STEP(1), .START_AMOUNT(3), .MAX_AMOUNT(3)) dut2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start2),
        .pause(pause), .game_over(game_over), .player_hit(player_hit),
        .plane_amount(amt2), .step_pulse(stp2), .state(st2)
    );

    typedef struct {
        logic       s, p, g, h, t;
        logic [3:0] amt;
        logic [1:0] st;
        logic       stp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic g, input logic h, input logic t);
        @(negedge clk);
        start = s; pause = p; game_over = g; player_hit = h; frame_tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input logic p, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, p, 1'b0, 1'b0, 1'b1);
            if (stp === 1'b1) pulses++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0; start2 = 1'b0; pause = 1'b0;
        game_over = 1'b0; player_hit = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int np;
        reset = 1'b1;
        start = 1'b0; start2 = 1'b0; pause = 1'b0;
        game_over = 1'b0; player_hit = 1'b0; frame_tick = 1'b0;

        //           s     p     g     h     t     amt   st    stp
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0}; // tick in IDLE ignored
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 2'd1, 1'b0}; // start
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0}; // cnt 1
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0}; // paused tick
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 2'd1, 1'b0}; // cnt 2
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 2'd1, 1'b1}; // step
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 2'd1, 1'b0}; // pulse drops
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 2'd3, 1'b0}; // game_over
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 2'd3, 1'b0}; // tick in OVER
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 2'd3, 1'b0}; // game_over in OVER
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 2'd1, 1'b0}; // start beats game_over
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 2'd1, 1'b0}; // hit at START

        #12;
        chk("reset_amount", 16'(amt), 16'd0);
        chk("reset_state", 16'(st), 16'd0);
        chk("reset_step", 16'(stp), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // START_AMOUNT == MAX_AMOUNT goes straight to MAXED
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        chk("eq_start_state", 16'(st2), 16'd2);
        chk("eq_start_amount", 16'(amt2), 16'd3);
        @(negedge clk);
        start2 = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        chk("eq_tick_amount", 16'(amt2), 16'd3);
        chk("eq_tick_step", 16'(stp2), 16'd0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].g, tbl[i].h, tbl[i].t);
            chk($sformatf("vec%0d_amount", i), 16'(amt), 16'(tbl[i].amt));
            chk($sformatf("vec%0d_state", i), 16'(st), 16'(tbl[i].st));
            chk($sformatf("vec%0d_step", i), 16'(stp), 16'(tbl[i].stp));
        end

        // full ramp: 27 ticks to the ceiling
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(26, 1'b0, np);
        chk("ramp_amount_t26", 16'(amt), 16'd9);
        chk("ramp_state_t26", 16'(st), 16'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (stp === 1'b1) np++;
        chk("ramp_amount_t27", 16'(amt), 16'd10);
        chk("ramp_state_t27", 16'(st), 16'd2);
        chk("ramp_pulses", 16'(np), 16'd9);
        ticks(6, 1'b0, np);
        chk("maxed_amount", 16'(amt), 16'd10);
        chk("maxed_pulses", 16'(np), 16'd0);

`ifdef HIT_PENALTY_EN
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hit_amount", 16'(amt), 16'd9);
        chk("hit_state", 16'(st), 16'd1);
        chk("hit_step", 16'(stp), 16'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("hit_step_drop", 16'(stp), 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hit_floor_amount", 16'(amt), 16'd1);
        chk("hit_floor_step", 16'(stp), 16'd0);
`else
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hit_ignored_amount", 16'(amt), 16'd10);
        chk("hit_ignored_state", 16'(st), 16'd2);
        chk("hit_ignored_step", 16'(stp), 16'd0);
`endif

        // pause holds the frame counter
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2, 1'b0, np);
        ticks(5, 1'b1, np);
        chk("pause_amount", 16'(amt), 16'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("unpause_amount", 16'(amt), 16'd2);
        chk("unpause_step", 16'(stp), 16'd1);

        // game_over on the final tick of a step wins
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(9, 1'b0, np);
        chk("go_pre_amount", 16'(amt), 16'd4);
        ticks(2, 1'b0, np);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("go_state", 16'(st), 16'd3);
        chk("go_amount", 16'(amt), 16'd4);
        chk("go_step", 16'(stp), 16'd0);

        // asynchronous reset mid-cycle
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ticks(15, 1'b0, np);
        chk("ar_pre_amount", 16'(amt), 16'd6);
        @(negedge clk);
        frame_tick = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ar_amount", 16'(amt), 16'd0);
        chk("ar_state", 16'(st), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ar_restart_amount", 16'(amt), 16'd1);
        chk("ar_restart_state", 16'(st), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
